zombie_hit_judge: RTL and testbench
===================================

ZOMBIE_HIT_JUDGE -- requirements
Module: zombie_hit_judge

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 625000, meaning clocks a raw button must hold one level before the debounced value follows it.
REQ-002 SHALL have parameter WINDOW_CYCLES, default 62500000, meaning clocks allowed to hit an armed target (timeout build only).
REQ-003 SHALL have parameter LIVES_INIT, default 3, range 1..3, meaning lives loaded at reset.
REQ-004 SHALL have the port clk, input, 1 bit, meaning the single clock; all flops use its rising edge.
REQ-005 SHALL have the port rst_n, input, 1 bit, meaning reset; asynchronous and active-low.
REQ-006 SHALL have the ports btn1, btn2 and btn3, input, 1 bit each, meaning raw asynchronous player buttons, active-high.
REQ-007 SHALL have the port led, input, 4 bits, meaning the one-hot target from the spawner: bit1, bit2 or bit3 maps to btn1, btn2 or btn3; bit0 is ignored.
REQ-008 SHALL have the ports hit and miss, output, 1 bit each, meaning one-cycle judgement pulses.
REQ-009 SHALL have the port score, output, 8 bits, meaning the hit count.
REQ-010 SHALL have the port lives, output, 2 bits, meaning remaining lives.
REQ-011 SHALL have the port game_over, output, 1 bit, meaning the level flag that is high when lives are 0.

Function
REQ-012 SHALL pass each button through a 2-flop synchroniser, then a per-button debounce counter; the counter reloads on any mismatch.
REQ-013 SHALL generate a one-cycle press event on each rising edge of a debounced button.
REQ-014 SHALL treat led as a valid target only when exactly one of led[3:1] is set.
REQ-015 SHALL implement FSM states IDLE, ARMED, COOLDOWN and OVER.
REQ-016 Transition IDLE->ARMED: taken when a valid target is present; the target is latched and the window counter cleared.
REQ-017 In ARMED, a cycle with exactly one press event that matches the latched target SHALL pulse hit in the next cycle and increment score.
REQ-018 Score arithmetic: score saturates at 255.
REQ-019 In ARMED, a cycle with a non-matching press, or with 2 or more simultaneous presses, SHALL pulse miss in the next cycle and decrement lives; this miss is judged in the same way as a wrong press.
REQ-020 After a hit or miss the FSM SHALL enter COOLDOWN.
REQ-021 If lives reach 0, the FSM SHALL enter OVER instead of COOLDOWN.
REQ-022 Transition COOLDOWN->IDLE: taken when all three debounced buttons are low.
REQ-023 Press events in IDLE, COOLDOWN or OVER SHALL be ignored: no pulse and no counter change.
REQ-024 In ARMED, if led changes to a different valid target with no press that cycle, the FSM SHALL re-latch the target and restart the window.
REQ-025 In ARMED, if led becomes invalid, the FSM SHALL return to IDLE with no judgement.
REQ-026 OVER SHALL be held until reset; game_over=1 there, and hit and miss stay 0.
REQ-027 hit and miss SHALL never be high in the same cycle.

Reset
REQ-028 While rst_n=0, the block SHALL hold hit=0, miss=0, score=0, lives=LIVES_INIT, game_over=0, state=IDLE, window and debounce counters cleared, and all debounced buttons 0.
REQ-029 A reset asserted mid-ARMED or mid-COOLDOWN SHALL discard any pending judgement, and no pulse SHALL follow deassertion.

Configuration
REQ-030 With ZOMBIE_TIMEOUT_EN defined, ARMED SHALL count clocks, and after WINDOW_CYCLES with no press SHALL pulse miss, decrement lives and go to COOLDOWN, or to OVER if lives reach 0.
REQ-031 With ZOMBIE_TIMEOUT_EN undefined, the block SHALL have no window counter, and ARMED SHALL wait indefinitely.

Verification (DEBOUNCE_CYCLES=4, WINDOW_CYCLES=20)
REQ-032 Test scenario: led=0010, btn1 high for 10 clocks -> one hit pulse, score=1, lives=3.
REQ-033 Test scenario: led=0100, btn3 pressed -> miss pulse, lives=2, score=0; btn3 held -> no further pulses until released.
REQ-034 Test scenario: btn2 toggling every 2 clocks for 20 clocks -> no press event and no pulse.
REQ-035 Test scenario: three consecutive wrong presses -> lives 2,1,0, game_over=1; a further correct press -> no hit, score unchanged.
REQ-036 Test scenario: timeout build, led=1000 and no press for 20 clocks -> miss one clock later; non-timeout build -> no pulse after 1000 clocks.
REQ-037 Test scenario: rst_n low for 1 clock in the cycle a matching press event occurs -> no hit, score=0, lives=3, state IDLE.

Source files
------------

// File: rtl/zombie_hit_judge.sv
// zombie_hit_judge: debounces three player buttons and judges each press
// against the one-hot target from the spawner, keeping score and lives.
// Optional feature macro: ZOMBIE_TIMEOUT_EN adds a hit window that turns an
// unanswered target into a miss after WINDOW_CYCLES clocks.
module zombie_hit_judge #(
    parameter int unsigned DEBOUNCE_CYCLES = 625000,
    parameter int unsigned WINDOW_CYCLES   = 62500000,
    parameter int unsigned LIVES_INIT      = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn1,
    input  logic       btn2,
    input  logic       btn3,
    input  logic [3:0] led,
    output logic       hit,
    output logic       miss,
    output logic [7:0] score,
    output logic [1:0] lives,
    output logic       game_over
);

    localparam int unsigned DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

`ifdef ZOMBIE_TIMEOUT_EN
    localparam int unsigned WIN_W = (WINDOW_CYCLES > 1) ? $clog2(WINDOW_CYCLES) : 1;
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW_CYCLES - 1);
`else
    localparam int unsigned window_cycles_unused = WINDOW_CYCLES;
`endif

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ARMED    = 2'd1,
        COOLDOWN = 2'd2,
        OVER     = 2'd3
    } state_t;

    state_t     state, state_nxt;
    logic [2:0] raw;
    logic [2:0] sync1, sync2;
    logic [2:0] db, db_prev;
    logic [2:0] press_c;
    logic [2:0] target, target_nxt;
    logic       hit_nxt, miss_nxt, game_over_nxt;
    logic [7:0] score_nxt;
    logic [1:0] lives_nxt;
    logic       led_valid_c, judge_hit_c, judge_miss_c, timeout_c;
    logic       led0_unused;

`ifdef ZOMBIE_TIMEOUT_EN
    logic [WIN_W-1:0] window, win_nxt;
`endif

    assign raw         = {btn3, btn2, btn1};
    assign led0_unused = led[0];

    // Two-flop synchroniser for the raw buttons
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 3'b000;
            sync2 <= 3'b000;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    // Per-button debounce: the level must stay different for DEBOUNCE_CYCLES clocks
    for (genvar i = 0; i < 3; i++) begin : g_db
        logic [DB_W-1:0] cnt;
        logic            q;

        // Counter restarts whenever the synchronised level agrees with the output
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt <= '0;
                q   <= 1'b0;
            end else if (sync2[i] == q) begin
                cnt <= '0;
            end else if (cnt == DB_LAST) begin
                cnt <= '0;
                q   <= sync2[i];
            end else begin
                cnt <= cnt + DB_W'(1);
            end
        end

        assign db[i] = q;
    end

    // Previous debounced level for rising-edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            db_prev <= 3'b000;
        end else begin
            db_prev <= db;
        end
    end

    assign press_c     = db & ~db_prev;
    assign led_valid_c = $onehot(led[3:1]);
    assign judge_hit_c = (state == ARMED) && $onehot(press_c) && (press_c == target);

`ifdef ZOMBIE_TIMEOUT_EN
    assign timeout_c = (state == ARMED) && (press_c == 3'b000) && led_valid_c
                       && (led[3:1] == target) && (window == WIN_LAST);
`else
    assign timeout_c = 1'b0;
`endif

    assign judge_miss_c = (state == ARMED) && !judge_hit_c
                          && ((press_c != 3'b000) || timeout_c);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (led_valid_c) state_nxt = ARMED;
            end
            ARMED: begin
                if (judge_hit_c)       state_nxt = COOLDOWN;
                else if (judge_miss_c) state_nxt = (lives == 2'd1) ? OVER : COOLDOWN;
                else if (!led_valid_c) state_nxt = IDLE;
            end
            COOLDOWN: begin
                if (db == 3'b000) state_nxt = IDLE;
            end
            OVER: begin
                state_nxt = OVER;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Next values of the registered outputs, target latch and window
    always_comb begin
        hit_nxt    = 1'b0;
        miss_nxt   = 1'b0;
        score_nxt  = score;
        lives_nxt  = lives;
        target_nxt = target;
`ifdef ZOMBIE_TIMEOUT_EN
        win_nxt    = window;
`endif
        case (state)
            IDLE: begin
                if (led_valid_c) begin
                    target_nxt = led[3:1];
`ifdef ZOMBIE_TIMEOUT_EN
                    win_nxt    = '0;
`endif
                end
            end
            ARMED: begin
                if (judge_hit_c) begin
                    hit_nxt   = 1'b1;
                    score_nxt = (score == 8'hFF) ? score : score + 8'd1;
                end else if (judge_miss_c) begin
                    miss_nxt  = 1'b1;
                    lives_nxt = lives - 2'd1;
                end else if (led_valid_c && (led[3:1] != target)) begin
                    target_nxt = led[3:1];
`ifdef ZOMBIE_TIMEOUT_EN
                    win_nxt    = '0;
`endif
                end else begin
`ifdef ZOMBIE_TIMEOUT_EN
                    win_nxt = window + WIN_W'(1);
`endif
                end
            end
            default: begin
            end
        endcase
        game_over_nxt = (lives_nxt == 2'd0);
    end

    // Output and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit       <= 1'b0;
            miss      <= 1'b0;
            score     <= 8'd0;
            lives     <= 2'(LIVES_INIT);
            game_over <= 1'b0;
            target    <= 3'b000;
`ifdef ZOMBIE_TIMEOUT_EN
            window    <= '0;
`endif
        end else begin
            hit       <= hit_nxt;
            miss      <= miss_nxt;
            score     <= score_nxt;
            lives     <= lives_nxt;
            game_over <= game_over_nxt;
            target    <= target_nxt;
`ifdef ZOMBIE_TIMEOUT_EN
            window    <= win_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_zombie_hit_judge.sv
// Testbench for zombie_hit_judge: directed scenarios plus randomized presses
// checked against a game-level reference model (score, lives, game over).
module tb_zombie_hit_judge;

    localparam int unsigned DEB = 4;
    localparam int unsigned WIN = 20;

    logic       clk;
    logic       rst_n;
    logic [2:0] btns;
    logic [3:0] led;
    logic       hit, miss, game_over;
    logic [7:0] score;
    logic [1:0] lives;

    int n_cmp;
    int n_fail;
    int hits_seen;
    int misses_seen;

    // Reference model state
    int m_score;
    int m_lives;
    bit m_over;

    zombie_hit_judge #(
        .DEBOUNCE_CYCLES(DEB),
        .WINDOW_CYCLES  (WIN),
        .LIVES_INIT     (3)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .btn1     (btns[0]),
        .btn2     (btns[1]),
        .btn3     (btns[2]),
        .led      (led),
        .hit      (hit),
        .miss     (miss),
        .score    (score),
        .lives    (lives),
        .game_over(game_over)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance n clocks, sampling on the falling edge and tallying pulses
    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            if (hit) hits_seen++;
            if (miss) misses_seen++;
            n_cmp++;
            if (hit && miss) begin
                n_fail++;
                $display("FAIL overlap: hit=%0b miss=%0b both high, required never both", hit, miss);
            end
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        btns  = 3'b000;
        led   = 4'b0000;
        tick(2);
        rst_n = 1'b1;
        tick(2);
        hits_seen   = 0;
        misses_seen = 0;
        m_score = 0;
        m_lives = 3;
        m_over  = 1'b0;
    endtask

    // Model of one judged press: what the game rules say must happen
    task automatic model_press(input logic [2:0] tgt, input logic [2:0] pm,
                               output int eh, output int em);
        eh = 0;
        em = 0;
        if (!m_over && pm != 3'b000) begin
            if (pm == tgt) begin
                eh = 1;
                if (m_score < 255) m_score++;
            end else begin
                em = 1;
                m_lives--;
                if (m_lives == 0) m_over = 1'b1;
            end
        end
    endtask

    // Arm a target, hold a button pattern, release and let the block settle
    task automatic play(input logic [3:0] l, input logic [2:0] pm, input int hold);
        led = l;
        tick(3);
        hits_seen   = 0;
        misses_seen = 0;
        btns = pm;
        tick(hold);
        btns = 3'b000;
        tick(16);
        led = 4'b0000;
        tick(2);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        btns  = 3'b111;
        led   = 4'b0010;
        tick(3);
        n_cmp++; if (hit !== 1'b0) begin n_fail++; $display("FAIL reset_hit: got %0b expected 0", hit); end
        n_cmp++; if (miss !== 1'b0) begin n_fail++; $display("FAIL reset_miss: got %0b expected 0", miss); end
        n_cmp++; if (score !== 8'd0) begin n_fail++; $display("FAIL reset_score: got %0d expected 0", score); end
        n_cmp++; if (lives !== 2'd3) begin n_fail++; $display("FAIL reset_lives: got %0d expected 3", lives); end
        n_cmp++; if (game_over !== 1'b0) begin n_fail++; $display("FAIL reset_game_over: got %0b expected 0", game_over); end
        do_reset();
    endtask

    task automatic test_hit();
        int eh, em;
        do_reset();
        model_press(3'b001, 3'b001, eh, em);
        play(4'b0010, 3'b001, 10);
        n_cmp++; if (hits_seen != eh) begin n_fail++; $display("FAIL hit_count: got %0d expected %0d", hits_seen, eh); end
        n_cmp++; if (misses_seen != em) begin n_fail++; $display("FAIL hit_miss_count: got %0d expected %0d", misses_seen, em); end
        n_cmp++; if (score !== 8'(m_score)) begin n_fail++; $display("FAIL hit_score: got %0d expected %0d", score, m_score); end
        n_cmp++; if (lives !== 2'(m_lives)) begin n_fail++; $display("FAIL hit_lives: got %0d expected %0d", lives, m_lives); end
    endtask

    task automatic test_miss_hold();
        do_reset();
        led = 4'b0100;
        tick(3);
        hits_seen   = 0;
        misses_seen = 0;
        btns = 3'b100;
        tick(12);
        n_cmp++; if (misses_seen != 1) begin n_fail++; $display("FAIL miss_count: got %0d expected 1", misses_seen); end
        n_cmp++; if (lives !== 2'd2) begin n_fail++; $display("FAIL miss_lives: got %0d expected 2", lives); end
        tick(30);
        btns = 3'b000;
        tick(16);
        led = 4'b0000;
        tick(2);
        n_cmp++; if (misses_seen != 1) begin n_fail++; $display("FAIL miss_held_count: got %0d expected 1", misses_seen); end
        n_cmp++; if (hits_seen != 0) begin n_fail++; $display("FAIL miss_held_hits: got %0d expected 0", hits_seen); end
        n_cmp++; if (score !== 8'd0) begin n_fail++; $display("FAIL miss_score: got %0d expected 0", score); end
    endtask

    task automatic test_bounce();
        do_reset();
        led = 4'b0100;
        tick(3);
        hits_seen   = 0;
        misses_seen = 0;
        for (int k = 0; k < 5; k++) begin
            btns = 3'b010;
            tick(2);
            btns = 3'b000;
            tick(2);
        end
        tick(12);
        led = 4'b0000;
        tick(2);
        n_cmp++; if (hits_seen + misses_seen != 0) begin n_fail++; $display("FAIL bounce_pulses: got %0d expected 0", hits_seen + misses_seen); end
        n_cmp++; if (score !== 8'd0) begin n_fail++; $display("FAIL bounce_score: got %0d expected 0", score); end
        n_cmp++; if (lives !== 2'd3) begin n_fail++; $display("FAIL bounce_lives: got %0d expected 3", lives); end
    endtask

    task automatic test_game_over();
        int eh, em;
        do_reset();
        for (int k = 0; k < 3; k++) begin
            model_press(3'b001, 3'b100, eh, em);
            play(4'b0010, 3'b100, 10);
            n_cmp++; if (misses_seen != em) begin n_fail++; $display("FAIL over_miss%0d: got %0d expected %0d", k, misses_seen, em); end
            n_cmp++; if (lives !== 2'(m_lives)) begin n_fail++; $display("FAIL over_lives%0d: got %0d expected %0d", k, lives, m_lives); end
        end
        n_cmp++; if (game_over !== 1'b1) begin n_fail++; $display("FAIL over_flag: got %0b expected 1", game_over); end
        model_press(3'b001, 3'b001, eh, em);
        play(4'b0010, 3'b001, 10);
        n_cmp++; if (hits_seen != eh) begin n_fail++; $display("FAIL over_hit_ignored: got %0d expected %0d", hits_seen, eh); end
        n_cmp++; if (score !== 8'(m_score)) begin n_fail++; $display("FAIL over_score: got %0d expected %0d", score, m_score); end
        n_cmp++; if (game_over !== 1'b1) begin n_fail++; $display("FAIL over_held: got %0b expected 1", game_over); end
    endtask

    task automatic test_retarget();
        do_reset();
        // Target moves from btn1 to btn3 before the press
        led = 4'b0010;
        tick(3);
        led = 4'b1000;
        tick(2);
        hits_seen   = 0;
        misses_seen = 0;
        btns = 3'b100;
        tick(10);
        btns = 3'b000;
        tick(16);
        led = 4'b0000;
        tick(2);
        n_cmp++; if (hits_seen != 1) begin n_fail++; $display("FAIL retarget_hit: got %0d expected 1", hits_seen); end
        n_cmp++; if (misses_seen != 0) begin n_fail++; $display("FAIL retarget_miss: got %0d expected 0", misses_seen); end
        // Two-hot and bit0-only targets are not valid, so presses are ignored
        play(4'b0110, 3'b010, 10);
        n_cmp++; if (hits_seen + misses_seen != 0) begin n_fail++; $display("FAIL twohot_pulses: got %0d expected 0", hits_seen + misses_seen); end
        play(4'b0001, 3'b001, 10);
        n_cmp++; if (hits_seen + misses_seen != 0) begin n_fail++; $display("FAIL bit0_pulses: got %0d expected 0", hits_seen + misses_seen); end
        n_cmp++; if (score !== 8'd1) begin n_fail++; $display("FAIL retarget_score: got %0d expected 1", score); end
        n_cmp++; if (lives !== 2'd3) begin n_fail++; $display("FAIL retarget_lives: got %0d expected 3", lives); end
    endtask

    task automatic test_timeout();
        int first_miss;
        do_reset();
        led = 4'b1000;
        first_miss = -1;
`ifdef ZOMBIE_TIMEOUT_EN
        for (int k = 1; k <= 40; k++) begin
            tick(1);
            if (misses_seen != 0 && first_miss < 0) first_miss = k;
        end
        // One IDLE clock to arm, WIN armed clocks, then the pulse
        n_cmp++; if (first_miss != int'(WIN) + 1) begin n_fail++; $display("FAIL timeout_cycle: got %0d expected %0d", first_miss, WIN + 1); end
        n_cmp++; if (lives !== 2'd2) begin n_fail++; $display("FAIL timeout_lives: got %0d expected 2", lives); end
`else
        tick(1000);
        n_cmp++; if (hits_seen + misses_seen != 0) begin n_fail++; $display("FAIL no_timeout_pulses: got %0d expected 0", hits_seen + misses_seen); end
        n_cmp++; if (lives !== 2'd3) begin n_fail++; $display("FAIL no_timeout_lives: got %0d expected 3", lives); end
`endif
        led = 4'b0000;
        tick(2);
    endtask

    task automatic test_reset_mid();
        int eh, em;
        do_reset();
        led = 4'b0010;
        tick(3);
        hits_seen   = 0;
        misses_seen = 0;
        btns = 3'b001;
        // 2 synchroniser clocks then DEB stable clocks: press event is live now
        tick(2 + DEB);
        n_cmp++; if (hits_seen != 0) begin n_fail++; $display("FAIL midreset_early_hit: got %0d expected 0", hits_seen); end
        rst_n = 1'b0;
        btns  = 3'b000;
        tick(1);
        rst_n = 1'b1;
        tick(20);
        n_cmp++; if (hits_seen + misses_seen != 0) begin n_fail++; $display("FAIL midreset_pulses: got %0d expected 0", hits_seen + misses_seen); end
        n_cmp++; if (score !== 8'd0) begin n_fail++; $display("FAIL midreset_score: got %0d expected 0", score); end
        n_cmp++; if (lives !== 2'd3) begin n_fail++; $display("FAIL midreset_lives: got %0d expected 3", lives); end
        // Block comes back idle and judges the next press normally
        m_score = 0; m_lives = 3; m_over = 1'b0;
        model_press(3'b001, 3'b001, eh, em);
        play(4'b0010, 3'b001, 10);
        n_cmp++; if (hits_seen != eh) begin n_fail++; $display("FAIL midreset_after_hit: got %0d expected %0d", hits_seen, eh); end
        n_cmp++; if (score !== 8'(m_score)) begin n_fail++; $display("FAIL midreset_after_score: got %0d expected %0d", score, m_score); end
    endtask

    task automatic test_random();
        int eh, em, over_rounds;
        logic [2:0] tgt, pm;
        logic [3:0] l;
        do_reset();
        over_rounds = 0;
        for (int k = 0; k < 30; k++) begin
            tgt = 3'(1 << $urandom_range(0, 2));
            pm  = 3'($urandom_range(1, 7));
            l   = {tgt, 1'($urandom_range(0, 1))};
            model_press(tgt, pm, eh, em);
            play(l, pm, int'($urandom_range(8, 14)));
            n_cmp++; if (hits_seen != eh) begin n_fail++; $display("FAIL rnd%0d_hit: tgt=%b press=%b got %0d expected %0d", k, tgt, pm, hits_seen, eh); end
            n_cmp++; if (misses_seen != em) begin n_fail++; $display("FAIL rnd%0d_miss: tgt=%b press=%b got %0d expected %0d", k, tgt, pm, misses_seen, em); end
            n_cmp++; if (score !== 8'(m_score)) begin n_fail++; $display("FAIL rnd%0d_score: got %0d expected %0d", k, score, m_score); end
            n_cmp++; if (lives !== 2'(m_lives)) begin n_fail++; $display("FAIL rnd%0d_lives: got %0d expected %0d", k, lives, m_lives); end
            n_cmp++; if (game_over !== m_over) begin n_fail++; $display("FAIL rnd%0d_game_over: got %0b expected %0b", k, game_over, m_over); end
            if (m_over) begin
                over_rounds++;
                if (over_rounds >= 2) begin
                    do_reset();
                    over_rounds = 0;
                end
            end
        end
    endtask

    // Hard stop in case the sequence ever stalls
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail + 1);
        $fatal(1);
    end

    initial begin
        n_cmp       = 0;
        n_fail      = 0;
        hits_seen   = 0;
        misses_seen = 0;
        rst_n = 1'b0;
        btns  = 3'b000;
        led   = 4'b0000;
        test_reset();
        test_hit();
        test_miss_hold();
        test_bounce();
        test_game_over();
        test_retarget();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
